// File: rtl/x1_load_arbiter.sv
// X1 main-memory arbiter: shares the single-port memory between the ioctl
// download stream (IPL ROM / CG font images) and the Z80 bus unit. It also
// paces the HPS with ioctl_wait and holds the CPU in reset across a download.
module x1_load_arbiter #(
    parameter int                ADDR_W     = 18,
    parameter logic [ADDR_W-1:0] IPL_BASE   = 18'h00000,
    parameter int                IPL_SIZE   = 4096,
    parameter logic [ADDR_W-1:0] FONT_BASE  = 18'h01000,
    parameter int                FONT_SIZE  = 2048,
    parameter int                MEM_LAT    = 2,
    parameter int                RESET_HOLD = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam int CNT_MAX = (MEM_LAT > RESET_HOLD) ? MEM_LAT : RESET_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LD_WR,
        CPU_ACC,
        CPU_ACK,
        POST_LOAD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_data;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [7:0]        acc_wdata;
    logic              load_active;
    logic              wr_hit;
    logic [ADDR_W-1:0] wr_addr;

    // The HPS is held off while a write is queued or being performed.
    assign ioctl_wait = pend_valid || (state == LD_WR);

    // Decode an ioctl strobe into an accepted write and its memory address.
    always_comb begin
        wr_hit  = 1'b0;
        wr_addr = '0;
        if (ioctl_wr && !ioctl_wait) begin
            if (ioctl_index == 8'd0 && ioctl_addr < 25'(IPL_SIZE)) begin
                wr_hit  = 1'b1;
                wr_addr = IPL_BASE + ioctl_addr[ADDR_W-1:0];
            end else if (ioctl_index == 8'd1 && ioctl_addr < 25'(FONT_SIZE)) begin
                wr_hit  = 1'b1;
                wr_addr = FONT_BASE + ioctl_addr[ADDR_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and memory/ack outputs decoded from the current state.
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_oe     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_hit || pend_valid) begin
                    state_next = LD_WR;
                end else if (load_active && !ioctl_download) begin
                    state_next = POST_LOAD;
                end else if (cpu_req && !ioctl_download && !cpu_reset) begin
                    state_next = CPU_ACC;
                end
            end
            LD_WR: begin
                mem_we    = 1'b1;
                mem_addr  = pend_addr;
                mem_wdata = pend_data;
                if (cnt == CNT_W'(MEM_LAT - 1)) begin
                    state_next = IDLE;
                end
            end
            CPU_ACC: begin
                mem_we    = acc_we;
                mem_oe    = !acc_we;
                mem_addr  = acc_addr;
                mem_wdata = acc_we ? acc_wdata : 8'h00;
                if (cnt == CNT_W'(MEM_LAT - 1)) begin
                    state_next = CPU_ACK;
                end
            end
            CPU_ACK: begin
                cpu_ack    = 1'b1;
                state_next = IDLE;
            end
            POST_LOAD: begin
                if (ioctl_download || cnt == CNT_W'(RESET_HOLD - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: pending write, CPU access latch, cycle counter, reset/status flags.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt         <= '0;
            pend_valid  <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            acc_we      <= 1'b0;
            acc_addr    <= '0;
            acc_wdata   <= '0;
            cpu_din     <= '0;
            cpu_reset   <= 1'b1;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            load_active <= 1'b0;
        end else begin
            cnt <= (state_next == state) ? cnt + 1'b1 : '0;

            if (wr_hit) begin
                pend_addr <= wr_addr;
                pend_data <= ioctl_dout;
            end
            if (state == IDLE && state_next == LD_WR) begin
                pend_valid <= 1'b0;
            end else if (wr_hit) begin
                pend_valid <= 1'b1;
            end

            if (ioctl_wr && ioctl_wait) begin
                load_err <= 1'b1;
            end

            if (state == IDLE && state_next == CPU_ACC) begin
                acc_we    <= cpu_we;
                acc_addr  <= cpu_addr;
                acc_wdata <= cpu_dout;
            end
            if (state == CPU_ACC && state_next == CPU_ACK && !acc_we) begin
                cpu_din <= mem_rdata;
            end

            if (state == IDLE && state_next == POST_LOAD) begin
                load_active <= 1'b0;
            end
            if (ioctl_download) begin
                cpu_reset   <= 1'b1;
                load_done   <= 1'b0;
                load_active <= 1'b1;
            end else if (state == POST_LOAD && state_next == IDLE) begin
                cpu_reset <= 1'b0;
                load_done <= 1'b1;
            end
        end
    end

endmodule
